// File: rtl/axi4_apb_bridge_nslv_if.sv
// AXI4 single-beat channel bundle for the AXI-to-APB bridge.
// With AXI4_APB_BRIDGE_APB4_EN defined, AW/AR also carry a 3-bit prot field.
interface axi4_apb_bridge_nslv_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 5
);
    logic                    aw_valid;
    logic                    aw_ready;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [ID_WIDTH-1:0]     aw_id;
    logic                    w_valid;
    logic                    w_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    b_valid;
    logic                    b_ready;
    logic [1:0]              b_resp;
    logic [ID_WIDTH-1:0]     b_id;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [ID_WIDTH-1:0]     ar_id;
    logic                    r_valid;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic [ID_WIDTH-1:0]     r_id;
    logic                    r_last;
`ifdef AXI4_APB_BRIDGE_APB4_EN
    logic [2:0]              aw_prot;
    logic [2:0]              ar_prot;
`endif

    modport master (
`ifdef AXI4_APB_BRIDGE_APB4_EN
        output aw_prot, ar_prot,
`endif
        output aw_valid, aw_addr, aw_id, w_valid, w_data, w_strb, b_ready,
        output ar_valid, ar_addr, ar_id, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp, b_id,
        input  ar_ready, r_valid, r_data, r_resp, r_id, r_last
    );

    modport slave (
`ifdef AXI4_APB_BRIDGE_APB4_EN
        input  aw_prot, ar_prot,
`endif
        input  aw_valid, aw_addr, aw_id, w_valid, w_data, w_strb, b_ready,
        input  ar_valid, ar_addr, ar_id, r_ready,
        output aw_ready, w_ready, b_valid, b_resp, b_id,
        output ar_ready, r_valid, r_data, r_resp, r_id, r_last
    );
endinterface

// File: rtl/axi4_apb_bridge_nslv.sv
// Single-beat AXI4 slave to APB3 master bridge with NUM_SLAVES decoded PSEL lines.
// Define AXI4_APB_BRIDGE_APB4_EN to add o_pstrb/o_pprot (APB4 signalling).
module axi4_apb_bridge_nslv #(
    parameter int unsigned             ADDR_WIDTH     = 32,
    parameter int unsigned             DATA_WIDTH     = 32,
    parameter int unsigned             ID_WIDTH       = 5,
    parameter int unsigned             NUM_SLAVES     = 4,
    parameter logic [ADDR_WIDTH-1:0]   SLV_BASE_ADDR  = 'h10000,
    parameter int unsigned             SLV_SIZE_LOG2  = 12,
    parameter int unsigned             TIMEOUT_CYCLES = 256
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    axi4_apb_bridge_nslv_if.slave            axi,
    output logic [ADDR_WIDTH-1:0]            o_paddr,
    output logic [NUM_SLAVES-1:0]            o_psel,
    output logic                             o_penable,
    output logic                             o_pwrite,
    output logic [DATA_WIDTH-1:0]            o_pwdata,
`ifdef AXI4_APB_BRIDGE_APB4_EN
    output logic [DATA_WIDTH/8-1:0]          o_pstrb,
    output logic [2:0]                       o_pprot,
`endif
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_prdata,
    input  logic [NUM_SLAVES-1:0]            i_pready,
    input  logic [NUM_SLAVES-1:0]            i_pslverr
);
    localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] SLOT_LIMIT = ADDR_WIDTH'(NUM_SLAVES);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e                  r_state;
    logic                    r_wr_prio;
    logic                    r_write;
    logic [ID_WIDTH-1:0]     r_id;
    logic [IDX_W-1:0]        r_idx;
    logic [CNT_W-1:0]        r_tcnt;
    logic [ADDR_WIDTH-1:0]   r_paddr;
    logic [NUM_SLAVES-1:0]   r_psel;
    logic                    r_penable;
    logic                    r_pwrite;
    logic [DATA_WIDTH-1:0]   r_pwdata;
    logic                    r_bvalid;
    logic [1:0]              r_bresp;
    logic                    r_rvalid;
    logic [1:0]              r_rresp;
    logic [DATA_WIDTH-1:0]   r_rdata;
`ifdef AXI4_APB_BRIDGE_APB4_EN
    logic [DATA_WIDTH/8-1:0] r_pstrb;
    logic [2:0]              r_pprot;
`else
    logic                    w_unused_strb;
    assign w_unused_strb = ^axi.w_strb;
`endif

    logic                  w_idle;
    logic                  w_wr_elig;
    logic                  w_rd_elig;
    logic                  w_grant_wr;
    logic                  w_grant_rd;
    logic [ADDR_WIDTH-1:0] w_acc_addr;
    logic [ADDR_WIDTH-1:0] w_off;
    logic [ADDR_WIDTH-1:0] w_slot;
    logic                  w_hit;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_sel_ready;
    logic                  w_sel_err;
    logic [DATA_WIDTH-1:0] w_sel_rdata;
    logic [DATA_WIDTH-1:0] w_prdata_arr [NUM_SLAVES];

    for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_prdata
        assign w_prdata_arr[k] = i_prdata[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin between directions only matters when both are eligible.
    assign w_idle     = (r_state == StIdle);
    assign w_wr_elig  = axi.aw_valid && axi.w_valid;
    assign w_rd_elig  = axi.ar_valid;
    assign w_grant_wr = w_idle && w_wr_elig && (!w_rd_elig || r_wr_prio);
    assign w_grant_rd = w_idle && w_rd_elig && (!w_wr_elig || !r_wr_prio);

    assign w_acc_addr = w_grant_wr ? axi.aw_addr : axi.ar_addr;
    assign w_off      = w_acc_addr - SLV_BASE_ADDR;
    assign w_slot     = w_off >> SLV_SIZE_LOG2;
    assign w_hit      = (w_acc_addr >= SLV_BASE_ADDR) && (w_slot < SLOT_LIMIT);
    assign w_idx      = w_slot[IDX_W-1:0];

    assign w_sel_ready = i_pready[r_idx];
    assign w_sel_err   = i_pslverr[r_idx];
    assign w_sel_rdata = w_prdata_arr[r_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_wr_prio <= 1'b1;
            r_write   <= 1'b0;
            r_id      <= '0;
            r_idx     <= '0;
            r_tcnt    <= '0;
            r_paddr   <= '0;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= '0;
            r_rvalid  <= 1'b0;
            r_rresp   <= '0;
            r_rdata   <= '0;
`ifdef AXI4_APB_BRIDGE_APB4_EN
            r_pstrb   <= '0;
            r_pprot   <= '0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_grant_wr || w_grant_rd) begin
                        r_wr_prio <= w_grant_rd;
                        r_write   <= w_grant_wr;
                        r_id      <= w_grant_wr ? axi.aw_id : axi.ar_id;
                        r_idx     <= w_idx;
                        r_tcnt    <= '0;
                        if (w_hit) begin
                            r_paddr   <= w_acc_addr;
                            r_pwrite  <= w_grant_wr;
                            r_pwdata  <= w_grant_wr ? axi.w_data : '0;
                            r_psel    <= NUM_SLAVES'(1) << w_idx;
                            r_penable <= 1'b0;
`ifdef AXI4_APB_BRIDGE_APB4_EN
                            r_pstrb   <= w_grant_wr ? axi.w_strb : '0;
                            r_pprot   <= w_grant_wr ? axi.aw_prot : axi.ar_prot;
`endif
                            r_state   <= StSetup;
                        end else begin
                            // Decode miss answers directly without touching the APB bus.
                            if (w_grant_wr) begin
                                r_bvalid <= 1'b1;
                                r_bresp  <= RespDecErr;
                            end else begin
                                r_rvalid <= 1'b1;
                                r_rresp  <= RespDecErr;
                                r_rdata  <= '0;
                            end
                            r_state <= StResp;
                        end
                    end
                end
                StSetup: begin
                    r_penable <= 1'b1;
                    r_state   <= StAccess;
                end
                StAccess: begin
                    // A pready in the last counted cycle is checked first so it beats the timeout.
                    if (w_sel_ready || (r_tcnt == CNT_LAST)) begin
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_state   <= StResp;
                        if (r_write) begin
                            r_bvalid <= 1'b1;
                            r_bresp  <= (!w_sel_ready || w_sel_err) ? RespSlvErr : RespOkay;
                        end else begin
                            r_rvalid <= 1'b1;
                            r_rresp  <= (!w_sel_ready || w_sel_err) ? RespSlvErr : RespOkay;
                            r_rdata  <= w_sel_ready ? w_sel_rdata : '0;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                StResp: begin
                    if (r_bvalid && axi.b_ready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= StIdle;
                    end
                    if (r_rvalid && axi.r_ready) begin
                        r_rvalid <= 1'b0;
                        r_state  <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign axi.aw_ready = w_grant_wr;
    assign axi.w_ready  = w_grant_wr;
    assign axi.ar_ready = w_grant_rd;
    assign axi.b_valid  = r_bvalid;
    assign axi.b_resp   = r_bresp;
    assign axi.b_id     = r_id;
    assign axi.r_valid  = r_rvalid;
    assign axi.r_resp   = r_rresp;
    assign axi.r_data   = r_rdata;
    assign axi.r_id     = r_id;
    assign axi.r_last   = r_rvalid;

    assign o_paddr   = r_paddr;
    assign o_psel    = r_psel;
    assign o_penable = r_penable;
    assign o_pwrite  = r_pwrite;
    assign o_pwdata  = r_pwdata;
`ifdef AXI4_APB_BRIDGE_APB4_EN
    assign o_pstrb   = r_pstrb;
    assign o_pprot   = r_pprot;
`endif
endmodule

// File: tb/tb_axi4_apb_bridge_nslv.sv
// Directed bench for axi4_apb_bridge_nslv: hit/miss/wait/timeout/arbitration/reset cases.
// Inputs change on the falling edge; outputs are sampled there or 1ns later.
module tb_axi4_apb_bridge_nslv;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  paddr;
    logic [3:0]   psel;
    logic         penable;
    logic         pwrite;
    logic [31:0]  pwdata;
    logic [127:0] prdata;
    logic [3:0]   pready;
    logic [3:0]   pslverr;
`ifdef AXI4_APB_BRIDGE_APB4_EN
    logic [3:0]   pstrb;
    logic [2:0]   pprot;
`endif
    int unsigned  n_checks = 0;
    int unsigned  n_errors = 0;

    axi4_apb_bridge_nslv_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(5)) axi ();

    axi4_apb_bridge_nslv #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .axi       (axi),
        .o_paddr   (paddr),
        .o_psel    (psel),
        .o_penable (penable),
        .o_pwrite  (pwrite),
        .o_pwdata  (pwdata),
`ifdef AXI4_APB_BRIDGE_APB4_EN
        .o_pstrb   (pstrb),
        .o_pprot   (pprot),
`endif
        .i_prdata  (prdata),
        .i_pready  (pready),
        .i_pslverr (pslverr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_axi();
        axi.aw_valid = 1'b0; axi.aw_addr = '0; axi.aw_id = '0;
        axi.w_valid  = 1'b0; axi.w_data  = '0; axi.w_strb = '0;
        axi.ar_valid = 1'b0; axi.ar_addr = '0; axi.ar_id = '0;
`ifdef AXI4_APB_BRIDGE_APB4_EN
        axi.aw_prot = '0; axi.ar_prot = '0;
`endif
    endtask

    task automatic drive_wr(input logic [31:0] addr, input logic [31:0] data, input logic [4:0] id);
        axi.aw_valid = 1'b1; axi.aw_addr = addr; axi.aw_id = id;
        axi.w_valid  = 1'b1; axi.w_data  = data; axi.w_strb = 4'hF;
    endtask

    task automatic drive_rd(input logic [31:0] addr, input logic [4:0] id);
        axi.ar_valid = 1'b1; axi.ar_addr = addr; axi.ar_id = id;
    endtask

    // Full write with bounded waits; used where exact cycle timing is already covered elsewhere.
    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [4:0] id, input logic [1:0] exp_resp);
        int unsigned n;
        logic        saw_sel;
        saw_sel = 1'b0;
        @(negedge clk);
        drive_wr(addr, data, id);
        n = 0;
        #1;
        while (!axi.aw_ready && n < 32) begin
            @(negedge clk); #1; n++;
        end
        check({tag, "_accept"}, axi.aw_ready, 1);
        @(negedge clk);
        clear_axi();
        n = 0;
        while (!axi.b_valid && n < 64) begin
            saw_sel = saw_sel | (|psel);
            @(negedge clk); n++;
        end
        check({tag, "_bvalid"}, axi.b_valid, 1);
        check({tag, "_bresp"}, axi.b_resp, exp_resp);
        check({tag, "_bid"}, axi.b_id, id);
        check({tag, "_saw_psel"}, saw_sel, 1);
        axi.b_ready = 1'b1;
        @(negedge clk);
        axi.b_ready = 1'b0;
        check({tag, "_bdone"}, axi.b_valid, 0);
    endtask

    initial begin
        clear_axi();
        axi.b_ready = 1'b0;
        axi.r_ready = 1'b0;
        prdata  = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_0000};
        pready  = 4'b1111;
        pslverr = 4'b0000;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_paddr", paddr, 0);
        check("rst_bvalid", axi.b_valid, 0);
        check("rst_rvalid", axi.r_valid, 0);
        rst_n = 1'b1;

        // 1: zero-wait write to slave 0
        @(negedge clk);
        drive_wr(32'h0001_0004, 32'hA5A5_0001, 5'd3);
        #1;
        check("t1_awready", axi.aw_ready, 1);
        check("t1_wready", axi.w_ready, 1);
        check("t1_arready", axi.ar_ready, 0);
        @(negedge clk);
        clear_axi();
        check("t1_setup_psel", psel, 4'b0001);
        check("t1_setup_pen", penable, 0);
        check("t1_pwrite", pwrite, 1);
        check("t1_paddr", paddr, 32'h0001_0004);
        check("t1_pwdata", pwdata, 32'hA5A5_0001);
        @(negedge clk);
        check("t1_access_psel", psel, 4'b0001);
        check("t1_access_pen", penable, 1);
        check("t1_early_b", axi.b_valid, 0);
        @(negedge clk);
        check("t1_psel_off", psel, 0);
        check("t1_bvalid", axi.b_valid, 1);
        check("t1_bresp", axi.b_resp, 2'b00);
        check("t1_bid", axi.b_id, 5'd3);
        @(negedge clk);
        check("t1_bheld", axi.b_valid, 1);
        axi.b_ready = 1'b1;
        @(negedge clk);
        axi.b_ready = 1'b0;
        check("t1_bdone", axi.b_valid, 0);

        // 2: read slave 2 with 3 wait states
        pready = 4'b1011;
        @(negedge clk);
        drive_rd(32'h0001_2008, 5'd7);
        #1;
        check("t2_arready", axi.ar_ready, 1);
        check("t2_awready", axi.aw_ready, 0);
        @(negedge clk);
        clear_axi();
        check("t2_setup_psel", psel, 4'b0100);
        check("t2_pwrite", pwrite, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_access_pen", penable, 1);
            check("t2_access_psel", psel, 4'b0100);
            check("t2_early_r", axi.r_valid, 0);
        end
        pready = 4'b1111;
        @(negedge clk);
        check("t2_rvalid", axi.r_valid, 1);
        check("t2_rdata", axi.r_data, 32'hDEAD_BEEF);
        check("t2_rresp", axi.r_resp, 2'b00);
        check("t2_rlast", axi.r_last, 1);
        check("t2_rid", axi.r_id, 5'd7);
        check("t2_psel_off", psel, 0);
        axi.r_ready = 1'b1;
        @(negedge clk);
        axi.r_ready = 1'b0;
        check("t2_rdone", axi.r_valid, 0);

        // 3: decode miss
        @(negedge clk);
        drive_rd(32'h0002_0000, 5'd1);
        #1;
        check("t3_arready", axi.ar_ready, 1);
        @(negedge clk);
        clear_axi();
        check("t3_rvalid", axi.r_valid, 1);
        check("t3_rresp", axi.r_resp, 2'b11);
        check("t3_rdata", axi.r_data, 0);
        check("t3_psel", psel, 0);
        check("t3_pen", penable, 0);
        axi.r_ready = 1'b1;
        @(negedge clk);
        axi.r_ready = 1'b0;
        check("t3_rdone", axi.r_valid, 0);

        // 4: slave 1 never ready, timeout after 16 ACCESS cycles
        pready = 4'b1101;
        @(negedge clk);
        drive_wr(32'h0001_1000, 32'h0BAD_F00D, 5'd2);
        #1;
        check("t4_awready", axi.aw_ready, 1);
        @(negedge clk);
        clear_axi();
        check("t4_setup_psel", psel, 4'b0010);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("t4_access_pen", penable, 1);
            check("t4_access_b", axi.b_valid, 0);
        end
        @(negedge clk);
        check("t4_psel_drop", psel, 0);
        check("t4_pen_drop", penable, 0);
        check("t4_bvalid", axi.b_valid, 1);
        check("t4_bresp", axi.b_resp, 2'b10);
        pready = 4'b1111;
        axi.b_ready = 1'b1;
        @(negedge clk);
        axi.b_ready = 1'b0;
        check("t4_bdone", axi.b_valid, 0);

        // Idle reset restores write priority for the arbitration test.
        rst_n = 1'b0;
        #1;
        check("rst2_psel", psel, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 5: simultaneous W and R, alternating grants; slave 3 reports an error
        pslverr = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_wr(32'h0001_0000, 32'h5000_0000 + k, 5'(k));
            drive_rd(32'h0001_3000, 5'(k + 8));
            #1;
            check("t5_grant_w", axi.aw_ready, (k % 2 == 0));
            check("t5_grant_r", axi.ar_ready, (k % 2 == 1));
            @(negedge clk);
            clear_axi();
            check("t5_psel", psel, (k % 2 == 0) ? 4'b0001 : 4'b1000);
            repeat (2) @(negedge clk);
            if (k % 2 == 0) begin
                check("t5_bvalid", axi.b_valid, 1);
                check("t5_bresp", axi.b_resp, 2'b00);
                check("t5_w_no_r", axi.r_valid, 0);
            end else begin
                check("t5_rvalid", axi.r_valid, 1);
                check("t5_rresp", axi.r_resp, 2'b10);
                check("t5_rdata", axi.r_data, 32'h3333_3333);
                check("t5_rlast", axi.r_last, 1);
                check("t5_rid", axi.r_id, 5'(k + 8));
            end
            axi.b_ready = 1'b1;
            axi.r_ready = 1'b1;
            @(negedge clk);
            axi.b_ready = 1'b0;
            axi.r_ready = 1'b0;
        end
        pslverr = 4'b0000;

        // 6: asynchronous reset during ACCESS
        pready = 4'b1110;
        @(negedge clk);
        drive_wr(32'h0001_0008, 32'hCAFE_0006, 5'd9);
        #1;
        check("t6_awready", axi.aw_ready, 1);
        @(negedge clk);
        clear_axi();
        check("t6_setup_psel", psel, 4'b0001);
        @(negedge clk);
        check("t6_access_pen", penable, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_psel", psel, 0);
        check("t6_rst_pen", penable, 0);
        check("t6_rst_paddr", paddr, 0);
        check("t6_rst_pwdata", pwdata, 0);
        check("t6_rst_bvalid", axi.b_valid, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        pready = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_no_b", axi.b_valid, 0);
        end
        axi_write("t6_next", 32'h0001_0010, 32'h1234_5678, 5'd4, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end
endmodule
